alarm_controller: RTL and testbench

Sequences the alarm once the wall-clock time equals the programmed alarm time. Owns the ring/snooze/dismiss behaviour: drives the alarm LED and blink output, counts snooze intervals and ring timeouts on the 1 Hz tick, and limits the number of snoozes. It sits between the time counter / alarm-set registers and the board LEDs. Its inputs are the current time, the alarm time and the 1 Hz tick; its outputs are the ring indicators.

---
 rtl/alarm_controller_if.sv | 30 +++
 rtl/alarm_controller.sv | 154 +++++++++++++++
 tb/tb_alarm_controller.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_controller_if.sv
// Alarm controller signal bundle: time/alarm inputs, tick, buttons and ring indicators.
interface alarm_controller_if;
  logic       tick_1hz;
  logic       alarm_en;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [4:0] a_hours;
  logic [5:0] a_minutes;
  logic [5:0] a_seconds;
  logic       snooze_but;
  logic       stop_but;
  logic       ring;
  logic       blink;
  logic       missed;
  logic [1:0] alarm_state;
  logic [1:0] snoozes_used;

  modport master (
    output tick_1hz, alarm_en, hours, minutes, seconds,
           a_hours, a_minutes, a_seconds, snooze_but, stop_but,
    input  ring, blink, missed, alarm_state, snoozes_used
  );

  modport slave (
    input  tick_1hz, alarm_en, hours, minutes, seconds,
           a_hours, a_minutes, a_seconds, snooze_but, stop_but,
    output ring, blink, missed, alarm_state, snoozes_used
  );
endinterface

// File: rtl/alarm_controller.sv
// Alarm sequencer: rings on time match, handles snooze/stop buttons,
// ring timeout on the 1 Hz tick and a per-event snooze limit.
module alarm_controller #(
  parameter int unsigned RING_TIMEOUT_S = 60,
  parameter int unsigned SNOOZE_S       = 300,
  parameter int unsigned MAX_SNOOZE     = 3
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  alarm_controller_if.slave ctl
);

  localparam logic [8:0] RING_TO = 9'(RING_TIMEOUT_S);
  localparam logic [8:0] SNZ_TO  = 9'(SNOOZE_S);
  localparam logic [1:0] MAX_SNZ = 2'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RINGING   = 2'd1,
    SNOOZE    = 2'd2,
    DISMISSED = 2'd3
  } state_t;

  state_t     state_q;
  logic [8:0] ring_cnt_q;
  logic [8:0] snz_cnt_q;
  logic [1:0] used_q;
  logic       ring_q;
  logic       blink_q;
  logic       missed_q;

  logic [1:0] snz_sync_q;
  logic       snz_prev_q;
  logic [1:0] stop_sync_q;
  logic       stop_prev_q;

  logic       snz_press;
  logic       stop_press;
  logic       match;
  logic [8:0] ring_cnt_inc;

  // Two-flop synchronizers plus previous-value flops for rising-edge detection
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      snz_sync_q  <= '0;
      snz_prev_q  <= 1'b0;
      stop_sync_q <= '0;
      stop_prev_q <= 1'b0;
    end else begin
      snz_sync_q  <= {snz_sync_q[0], ctl.snooze_but};
      snz_prev_q  <= snz_sync_q[1];
      stop_sync_q <= {stop_sync_q[0], ctl.stop_but};
      stop_prev_q <= stop_sync_q[1];
    end
  end

  assign snz_press    = snz_sync_q[1] & ~snz_prev_q;
  assign stop_press   = stop_sync_q[1] & ~stop_prev_q;
  assign ring_cnt_inc = ring_cnt_q + 9'd1;
  assign match        = ctl.alarm_en &&
                        (ctl.hours   == ctl.a_hours)   &&
                        (ctl.minutes == ctl.a_minutes) &&
                        (ctl.seconds == ctl.a_seconds);

  // Alarm state machine with registered ring/blink/missed outputs
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      used_q     <= '0;
      ring_q     <= 1'b0;
      blink_q    <= 1'b0;
      missed_q   <= 1'b0;
    end else begin
      // missed is acknowledged by a stop press while idle, independent of alarm_en
      if (state_q == IDLE && stop_press) missed_q <= 1'b0;

      if (!ctl.alarm_en) begin
        state_q    <= IDLE;
        ring_cnt_q <= '0;
        snz_cnt_q  <= '0;
        used_q     <= '0;
        ring_q     <= 1'b0;
        blink_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            used_q <= '0;
            if (match) begin
              state_q    <= RINGING;
              ring_cnt_q <= '0;
              ring_q     <= 1'b1;
              blink_q    <= 1'b1;
            end
          end
          RINGING: begin
            if (stop_press) begin
              state_q <= DISMISSED;
              ring_q  <= 1'b0;
              blink_q <= 1'b0;
            end else if (snz_press) begin
              if (used_q < MAX_SNZ) begin
                state_q   <= SNOOZE;
                snz_cnt_q <= SNZ_TO;
                used_q    <= used_q + 2'd1;
              end else begin
                state_q <= DISMISSED;
              end
              ring_q  <= 1'b0;
              blink_q <= 1'b0;
            end else if (ctl.tick_1hz) begin
              ring_cnt_q <= ring_cnt_inc;
              blink_q    <= ~blink_q;
              if (ring_cnt_inc == RING_TO) begin
                state_q  <= DISMISSED;
                missed_q <= 1'b1;
                ring_q   <= 1'b0;
                blink_q  <= 1'b0;
              end
            end
          end
          SNOOZE: begin
            if (stop_press) begin
              state_q <= DISMISSED;
            end else if (ctl.tick_1hz) begin
              snz_cnt_q <= snz_cnt_q - 9'd1;
              if (snz_cnt_q == 9'd1) begin
                state_q    <= RINGING;
                ring_cnt_q <= '0;
                ring_q     <= 1'b1;
                blink_q    <= 1'b1;
              end
            end
          end
          DISMISSED: begin
            if (!match) begin
              state_q <= IDLE;
              used_q  <= '0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ctl.ring         = ring_q;
  assign ctl.blink        = blink_q;
  assign ctl.missed       = missed_q;
  assign ctl.alarm_state  = state_q;
  assign ctl.snoozes_used = used_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: directed scenarios plus randomized stimulus,
// every cycle compared against a tick-timestamp reference model.
module tb_alarm_controller;

  localparam int unsigned RT = 10;
  localparam int unsigned SN = 5;
  localparam int unsigned MS = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  alarm_controller_if ifc ();

  alarm_controller #(
    .RING_TIMEOUT_S(RT),
    .SNOOZE_S      (SN),
    .MAX_SNOOZE    (MS)
  ) dut (
    .CLK100MHZ(clk),
    .reset    (rst_n),
    .ctl      (ifc.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode numbering 0 idle, 1 ringing, 2 snooze, 3 dismissed.
  // Ring and snooze timing are kept as absolute tick timestamps.
  int m_mode, m_used, m_total, m_start, m_wake;
  bit m_missed;
  bit snz_h[3];
  bit stp_h[3];

  int cur_h, cur_m, cur_s;
  bit adv;
  int tick_ctr;

  task automatic model_reset();
    m_mode = 0; m_used = 0; m_total = 0; m_start = 0; m_wake = 0; m_missed = 0;
    for (int i = 0; i < 3; i++) begin
      snz_h[i] = 0;
      stp_h[i] = 0;
    end
  endtask

  task automatic model_step();
    bit sp, tp, tk, en, mt;
    sp = snz_h[1] & ~snz_h[2];
    tp = stp_h[1] & ~stp_h[2];
    tk = ifc.tick_1hz;
    en = ifc.alarm_en;
    mt = en && cur_h == 7 && cur_m == 0 && cur_s == 0;
    if (m_mode == 0 && tp) m_missed = 0;
    if (!en) begin
      m_mode = 0;
      m_used = 0;
    end else begin
      case (m_mode)
        0: begin
          m_used = 0;
          if (mt) begin
            m_mode  = 1;
            m_start = m_total + int'(tk);
          end
        end
        1: begin
          if (tp) m_mode = 3;
          else if (sp) begin
            if (m_used < int'(MS)) begin
              m_mode = 2;
              m_used++;
              m_wake = m_total + int'(tk) + int'(SN);
            end else m_mode = 3;
          end else if (tk && (m_total + 1 - m_start) == int'(RT)) begin
            m_mode   = 3;
            m_missed = 1;
          end
        end
        2: begin
          if (tp) m_mode = 3;
          else if (tk && m_total + 1 == m_wake) begin
            m_mode  = 1;
            m_start = m_total + 1;
          end
        end
        default: begin
          if (!mt) begin
            m_mode = 0;
            m_used = 0;
          end
        end
      endcase
    end
    m_total += int'(tk);
    snz_h[2] = snz_h[1]; snz_h[1] = snz_h[0]; snz_h[0] = ifc.snooze_but;
    stp_h[2] = stp_h[1]; stp_h[1] = stp_h[0]; stp_h[0] = ifc.stop_but;
  endtask

  task automatic check_all();
    bit e_blink;
    e_blink = (m_mode == 1) && (((m_total - m_start) % 2) == 0);
    check("state",  32'(ifc.alarm_state),  32'(m_mode));
    check("ring",   32'(ifc.ring),         32'(m_mode == 1));
    check("blink",  32'(ifc.blink),        32'(e_blink));
    check("missed", 32'(ifc.missed),       32'(m_missed));
    check("used",   32'(ifc.snoozes_used), 32'(m_used));
  endtask

  task automatic set_time(input int h, input int m, input int s);
    cur_h = h; cur_m = m; cur_s = s;
    ifc.hours = 5'(h); ifc.minutes = 6'(m); ifc.seconds = 6'(s);
  endtask

  task automatic advance_time();
    cur_s++;
    if (cur_s == 60) begin cur_s = 0; cur_m++; end
    if (cur_m == 60) begin cur_m = 0; cur_h++; end
    if (cur_h == 24) cur_h = 0;
    set_time(cur_h, cur_m, cur_s);
  endtask

  // One clock: drive tick, model and DUT sample on posedge, compare on negedge.
  task automatic step();
    if (tick_ctr == 0) begin
      ifc.tick_1hz = 1'b1;
      tick_ctr = $urandom_range(0, 4);
    end else tick_ctr--;
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    check_all();
    if (ifc.tick_1hz && adv) advance_time();
    ifc.tick_1hz = 1'b0;
  endtask

  task automatic press(input bit s, input bit t, input int hold);
    ifc.snooze_but = s;
    ifc.stop_but   = t;
    repeat (hold) step();
    ifc.snooze_but = 1'b0;
    ifc.stop_but   = 1'b0;
    step();
  endtask

  task automatic wait_mode(input int m, input int budget);
    int k = 0;
    while (m_mode != m && k < budget) begin
      step();
      k++;
    end
    if (m_mode != m) check("wait_state", 32'(ifc.alarm_state), 32'(m));
  endtask

  // Reset asserted between clock edges; outputs must clear without an edge.
  task automatic async_reset(input int hold);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    repeat (hold) step();
    rst_n = 1'b1;
  endtask

  initial begin
    ifc.tick_1hz = 1'b0; ifc.alarm_en = 1'b0;
    ifc.snooze_but = 1'b0; ifc.stop_but = 1'b0;
    ifc.a_hours = 5'd7; ifc.a_minutes = 6'd0; ifc.a_seconds = 6'd0;
    set_time(0, 0, 0);
    adv = 1; tick_ctr = 3;
    model_reset();

    #1 rst_n = 1'b0;
    #1 check_all();
    repeat (2) step();
    rst_n = 1'b1;

    // Unanswered alarm times out, then acknowledge missed from idle
    ifc.alarm_en = 1'b1;
    set_time(6, 59, 58);
    wait_mode(1, 200);
    wait_mode(3, 400);
    wait_mode(0, 200);
    press(0, 1, 3);
    repeat (4) step();

    // Snooze to the limit; the extra press dismisses
    set_time(6, 59, 59);
    wait_mode(1, 200);
    for (int i = 0; i < 4; i++) begin
      press(1, 0, 2);
      if (i < 3) wait_mode(1, 400);
    end
    wait_mode(0, 200);

    // Stop while the match second persists: no retrigger
    adv = 0;
    set_time(7, 0, 0);
    wait_mode(1, 50);
    press(0, 1, 2);
    repeat (20) step();
    adv = 1;
    wait_mode(0, 100);

    // Stop and snooze on the same cycle
    set_time(6, 59, 59);
    wait_mode(1, 200);
    press(1, 0, 2);
    wait_mode(1, 400);
    press(1, 1, 2);
    wait_mode(0, 200);

    // alarm_en dropped in snooze, re-armed at a non-matching time
    set_time(6, 59, 59);
    wait_mode(1, 200);
    press(1, 0, 2);
    repeat (3) step();
    ifc.alarm_en = 1'b0;
    repeat (2) step();
    set_time(12, 0, 0);
    ifc.alarm_en = 1'b1;
    repeat (10) step();

    // Asynchronous reset mid-ring, then a fresh trigger
    set_time(6, 59, 59);
    wait_mode(1, 200);
    repeat (2) step();
    async_reset(3);
    set_time(6, 59, 59);
    wait_mode(1, 200);
    repeat (5) step();

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) ifc.alarm_en = ~ifc.alarm_en;
      else if (r < 5) begin
        if ($urandom_range(0, 1) == 1) set_time(7, 0, 0);
        else set_time(6, 59, $urandom_range(54, 59));
      end else if (r < 15) ifc.snooze_but = 1'($urandom_range(0, 1));
      else if (r < 19) ifc.stop_but = 1'($urandom_range(0, 1));
      else if (r == 19) async_reset($urandom_range(1, 3));
      else if (r < 23) adv = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
